// File: rtl/lpc_cycle_fifo.sv
// lpc_cycle_fifo: buffers LPC cycle words from lpc_periph and exposes them
// to the MCU through Wishbone pop-on-read registers with status, control
// and a level interrupt on threshold or overflow.
module lpc_cycle_fifo #(
    parameter int unsigned DEPTH_LOG2        = 4,
    parameter logic [31:0] DEFAULT_REG_VALUE = 32'hDEF_FAB_AC
) (
    input  logic        WBs_CLK_i,
    input  logic        WBs_RST_i,
    input  logic [16:0] WBs_ADR_i,
    input  logic        WBs_CYC_i,
    input  logic        WBs_STB_i,
    input  logic        WBs_WE_i,
    input  logic [3:0]  WBs_BYTE_STB_i,
    input  logic [31:0] WBs_DAT_i,
    output logic [31:0] WBs_DAT_o,
    output logic        WBs_ACK_o,
    input  logic [31:0] TDATA_i,
    input  logic        READY_i,
    output logic        IRQ_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]         count, count_n;
    logic [15:0]           ovf_cnt, ovf_cnt_n;
    logic                  overflow, overflow_n;
    logic                  irq_en, irq_en_n;
    logic [4:0]            threshold, threshold_n, eff_thr;
    logic                  ready_q;
    logic                  irq_n;
    logic [31:0]           rd_data_q, live_dat;

    logic       wb_req, sel_data, sel_status, sel_ctrl;
    logic       empty, full, pop, push_req, push, drop, ctrl_wr, flush;
    logic [7:0] reg_sel;

    assign wb_req     = WBs_CYC_i & WBs_STB_i;
    assign reg_sel    = WBs_ADR_i[9:2];
    assign sel_data   = (reg_sel == 8'h00);
    assign sel_status = (reg_sel == 8'h01);
    assign sel_ctrl   = (reg_sel == 8'h02);

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = sel_data & wb_req & ~WBs_WE_i & ~WBs_ACK_o & ~empty;
    assign push_req = READY_i & ~ready_q;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign ctrl_wr  = sel_ctrl & wb_req & WBs_WE_i & ~WBs_ACK_o;
    assign flush    = ctrl_wr & WBs_BYTE_STB_i[3] & WBs_DAT_i[31];

    logic unused_bits;
    assign unused_bits = ^{WBs_ADR_i[16:10], WBs_ADR_i[1:0], WBs_DAT_i[30:13],
                           WBs_DAT_i[7:1], WBs_BYTE_STB_i[2]};

    // Next-state of FIFO bookkeeping, control fields and interrupt level
    always_comb begin
        irq_en_n    = irq_en;
        threshold_n = threshold;
        wr_ptr_n    = wr_ptr;
        rd_ptr_n    = rd_ptr;
        count_n     = count;
        ovf_cnt_n   = ovf_cnt;
        overflow_n  = overflow;
        if (ctrl_wr & WBs_BYTE_STB_i[0]) irq_en_n    = WBs_DAT_i[0];
        if (ctrl_wr & WBs_BYTE_STB_i[1]) threshold_n = WBs_DAT_i[12:8];
        if (flush) begin
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
            count_n    = '0;
            ovf_cnt_n  = '0;
            overflow_n = 1'b0;
        end else begin
            if (push) wr_ptr_n = wr_ptr + 1'b1;
            if (pop)  rd_ptr_n = rd_ptr + 1'b1;
            if (push & ~pop) count_n = count + 1'b1;
            if (pop & ~push) count_n = count - 1'b1;
            if (drop) begin
                overflow_n = 1'b1;
                if (ovf_cnt != '1) ovf_cnt_n = ovf_cnt + 1'b1;
            end
        end
        eff_thr = (threshold_n == '0) ? 5'd1 : threshold_n;
        irq_n   = irq_en_n & ((32'(count_n) >= 32'(eff_thr)) | overflow_n);
    end

    // State registers, acknowledge and interrupt
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_cnt   <= '0;
            overflow  <= 1'b0;
            irq_en    <= 1'b0;
            threshold <= 5'd1;
            ready_q   <= 1'b0;
            WBs_ACK_o <= 1'b0;
            IRQ_o     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            ovf_cnt   <= ovf_cnt_n;
            overflow  <= overflow_n;
            irq_en    <= irq_en_n;
            threshold <= threshold_n;
            ready_q   <= READY_i;
            WBs_ACK_o <= wb_req & ~WBs_ACK_o;
            IRQ_o     <= irq_n;
            if (wb_req & ~WBs_ACK_o) rd_data_q <= live_dat;
        end
    end

    // Word storage; the flush-wins rule suppresses the write as well
    always_ff @(posedge WBs_CLK_i) begin
        if (push & ~flush) mem[wr_ptr] <= TDATA_i;
    end

    // Live register read mux
    always_comb begin
        live_dat = DEFAULT_REG_VALUE;
        if (sel_data)   live_dat = empty ? '0 : mem[rd_ptr];
        if (sel_status) live_dat = {ovf_cnt, 8'(count), 5'b0, overflow, full, empty};
        if (sel_ctrl)   live_dat = {1'b0, 18'b0, threshold, 7'b0, irq_en};
    end

    // The pop lands on the edge that raises ACK, so the value captured at that
    // edge is returned during ACK; this keeps the pre-pop head on the bus.
    assign WBs_DAT_o = WBs_ACK_o ? rd_data_q : live_dat;

endmodule

// File: tb/tb_lpc_cycle_fifo.sv
// tb_lpc_cycle_fifo: table-driven CTRL/register vectors plus scoreboarded
// FIFO sequences for lpc_cycle_fifo.
module tb_lpc_cycle_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] adr;
    logic        cyc, stb, we;
    logic [3:0]  be;
    logic [31:0] dat_w, dat_r;
    logic        ack;
    logic [31:0] tdata;
    logic        ready;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb[$];

    lpc_cycle_fifo #(.DEPTH_LOG2(4), .DEFAULT_REG_VALUE(32'hDEF_FAB_AC)) dut (
        .WBs_CLK_i     (clk),
        .WBs_RST_i     (rst),
        .WBs_ADR_i     (adr),
        .WBs_CYC_i     (cyc),
        .WBs_STB_i     (stb),
        .WBs_WE_i      (we),
        .WBs_BYTE_STB_i(be),
        .WBs_DAT_i     (dat_w),
        .WBs_DAT_o     (dat_r),
        .WBs_ACK_o     (ack),
        .TDATA_i       (tdata),
        .READY_i       (ready),
        .IRQ_o         (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [16:0] rd_adr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input int ovf, input int cnt, input bit ovflag);
        logic [31:0] s;
        s = '0;
        s[31:16] = 16'(ovf);
        s[15:8]  = 8'(cnt);
        s[2]     = ovflag;
        s[1]     = (cnt == 16);
        s[0]     = (cnt == 0);
        return s;
    endfunction

    task automatic wb_cycle(input logic [16:0] a, input logic w, input logic [31:0] wd,
                            input logic [3:0] b, output logic [31:0] rd);
        adr = a; we = w; dat_w = wd; be = b; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4 && !ack; i++) begin
            @(posedge clk); #1;
        end
        check("ack_rise", {31'b0, ack}, 32'd1);
        rd = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_pulse", {31'b0, ack}, 32'd0);
    endtask

    task automatic wb_write(input logic [16:0] a, input logic [31:0] wd, input logic [3:0] b);
        logic [31:0] dummy;
        wb_cycle(a, 1'b1, wd, b, dummy);
    endtask

    task automatic read_check(input string name, input logic [16:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_cycle(a, 1'b0, '0, 4'hF, d);
        check(name, d, exp);
    endtask

    task automatic pop_check(input string name);
        logic [31:0] d, exp;
        wb_cycle(17'h0, 1'b0, '0, 4'hF, d);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        check(name, d, exp);
    endtask

    task automatic push_word(input logic [31:0] w);
        tdata = w; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        @(posedge clk); #1;
        if (sb.size() < 16) sb.push_back(w);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d, e;

        tbl[0] = '{32'h0000_1F01, 4'b0011, 17'h08, 32'h0000_1F01};
        tbl[1] = '{32'h0000_0000, 4'b0001, 17'h08, 32'h0000_1F00};
        tbl[2] = '{32'h0000_0300, 4'b0010, 17'h08, 32'h0000_0300};
        tbl[3] = '{32'h8000_0101, 4'b0111, 17'h08, 32'h0000_0101};
        tbl[4] = '{32'h7FFF_E0FE, 4'b1111, 17'h08, 32'h0000_0000};
        tbl[5] = '{32'h0000_0100, 4'b0011, 17'h0C, 32'hDEF_FAB_AC};
        tbl[6] = '{32'h0000_0100, 4'b0011, 17'h10, 32'hDEF_FAB_AC};
        tbl[7] = '{32'h0000_0100, 4'b0011, 17'h04, 32'h0000_0001};

        rst = 1'b1; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; be = '0;
        dat_w = '0; tdata = '0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // reset state
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        read_check("rst_status", 17'h04, 32'h0000_0001);
        read_check("rst_ctrl", 17'h08, 32'h0000_0100);
        read_check("rst_data_empty", 17'h00, 32'h0);

        // CTRL write/readback and address decode vectors
        foreach (tbl[i]) begin
            wb_write(17'h08, tbl[i].wdata, tbl[i].be);
            read_check($sformatf("vec%0d", i), tbl[i].rd_adr, tbl[i].exp);
        end

        // three pushes, in-order reads, read-while-empty
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        push_word(32'h3333_3333);
        read_check("st3", 17'h04, status_word(0, 3, 1'b0));
        for (int i = 0; i < 3; i++) pop_check("rd_order");
        pop_check("rd_empty");
        read_check("st_empty", 17'h04, status_word(0, 0, 1'b0));

        // fill and overflow
        for (int i = 0; i < 18; i++) push_word(32'hA000_0000 + 32'(i));
        read_check("st_ovf", 17'h04, status_word(2, 16, 1'b1));
        for (int i = 0; i < 16; i++) pop_check("rd_ovf");
        read_check("st_ovf_drained", 17'h04, status_word(2, 0, 1'b1));
        wb_write(17'h08, 32'h8000_0000, 4'b1000);
        read_check("st_flushed", 17'h04, 32'h0000_0001);
        read_check("ctrl_after_flush", 17'h08, 32'h0000_0100);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push_word(32'hB000_0000 + 32'(i));
        tdata = 32'hC0FF_EE00; ready = 1'b1;
        adr = 17'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("simul_ack", {31'b0, ack}, 32'd1);
        e = sb.pop_front();
        check("simul_head", dat_r, e);
        sb.push_back(32'hC0FF_EE00);
        ready = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        read_check("st_simul", 17'h04, status_word(0, 16, 1'b0));
        for (int i = 0; i < 16; i++) pop_check("rd_simul");
        read_check("st_simul_drained", 17'h04, 32'h0000_0001);

        // threshold interrupt
        wb_write(17'h08, 32'h0000_0401, 4'b0011);
        read_check("ctrl_thr4", 17'h08, 32'h0000_0401);
        for (int i = 0; i < 3; i++) push_word(32'hD000_0000 + 32'(i));
        check("irq_below_thr", {31'b0, irq}, 32'd0);
        tdata = 32'hD000_0003; ready = 1'b1;
        @(posedge clk); #1;
        check("irq_at_thr", {31'b0, irq}, 32'd1);
        ready = 1'b0;
        sb.push_back(32'hD000_0003);
        @(posedge clk); #1;
        pop_check("rd_irq");
        check("irq_after_pop", {31'b0, irq}, 32'd0);
        wb_write(17'h08, 32'h8000_0000, 4'b1000);
        sb.delete();

        // threshold 0, then flush colliding with a push
        wb_write(17'h08, 32'h0000_0001, 4'b0011);
        push_word(32'hE000_0000);
        check("irq_thr0", {31'b0, irq}, 32'd1);
        for (int i = 1; i < 5; i++) push_word(32'hE000_0000 + 32'(i));
        read_check("st5", 17'h04, status_word(0, 5, 1'b0));
        tdata = 32'hE000_00FF; ready = 1'b1;
        adr = 17'h08; we = 1'b1; dat_w = 32'h8000_0001; be = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("flush_ack", {31'b0, ack}, 32'd1);
        check("flush_irq", {31'b0, irq}, 32'd0);
        ready = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        read_check("st_flush_push", 17'h04, 32'h0000_0001);
        read_check("ctrl_flush_rd0", 17'h08, 32'h0000_0001);

        // READY held high pushes once
        tdata = 32'hF000_0001; ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 ready = 1'b0;
        @(posedge clk); #1;
        sb.push_back(32'hF000_0001);
        read_check("st_hold", 17'h04, status_word(0, 1, 1'b0));

        // reset during a read
        adr = 17'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("mid_ack", {31'b0, ack}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_ack", {31'b0, ack}, 32'd0);
        check("rst_mid_irq", {31'b0, irq}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        read_check("st_after_rst", 17'h04, 32'h0000_0001);
        read_check("ctrl_after_rst", 17'h08, 32'h0000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
